// File: rtl/imem_loader.sv
// Boot image loader: syncs on MAGIC, takes LENGTH, writes LENGTH data words to
// instruction memory from address 0, then checks the additive checksum.
module imem_loader #(
    parameter int unsigned       WORD_WIDTH = 32,
    parameter int unsigned       ADDR_WIDTH = 10,
    parameter logic [WORD_WIDTH-1:0] MAGIC  = 32'hB007_10AD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic                  restart,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_WIDTH-1:0] imem_wdata,
    output logic                  load_done,
    output logic                  load_error,
    output logic                  cpu_rst_n
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    // Length is compared one bit wider than a word so DEPTH itself is representable.
    localparam logic [WORD_WIDTH:0] DEPTH = {{WORD_WIDTH{1'b0}}, 1'b1} << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
    logic [WORD_WIDTH-1:0] csum_q, csum_d;
    logic [WORD_WIDTH-1:0] rem_q, rem_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            csum_q  <= '0;
            rem_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            csum_q  <= csum_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        word_ready = (state_q == IDLE) || (state_q == LEN) ||
                     (state_q == DATA) || (state_q == CHECK);
    end

    assign accept = word_valid && word_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        csum_d  = csum_q;
        rem_d   = rem_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (accept && word_in == MAGIC) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    if (word_in == '0 || {1'b0, word_in} > DEPTH) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        rem_d   = word_in;
                        ptr_d   = '0;
                        csum_d  = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q[ADDR_WIDTH-1:0];
                    wdata_d = word_in;
                    ptr_d   = ptr_q + (ADDR_WIDTH+1)'(1);
                    csum_d  = csum_q + word_in;
                    rem_d   = rem_q - WORD_WIDTH'(1);
                    if (rem_q == WORD_WIDTH'(1)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    if (word_in == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE, ERROR: begin
                if (restart) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    ptr_d   = '0;
                    csum_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign load_done  = done_q;
    assign load_error = err_q;
    assign cpu_rst_n  = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-size instance plus a 4-word-deep
// instance for the length boundary cases.
module tb_imem_loader;

    localparam logic [31:0] MAGIC = 32'hB007_10AD;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        restart = 1'b0;

    logic        valid_a, ready_a, we_a, done_a, err_a, cpu_a;
    logic [9:0]  addr_a;
    logic [31:0] wdata_a;
    logic        valid_b, ready_b, we_b, done_b, err_b, cpu_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic        word_ready;

    assign valid_a    = word_valid & ~sel;
    assign valid_b    = word_valid & sel;
    assign word_ready = sel ? ready_b : ready_a;

    imem_loader dut (
        .clk(clk), .rst_n(rst_a), .word_in(word_in), .word_valid(valid_a),
        .word_ready(ready_a), .restart(restart & ~sel), .imem_we(we_a),
        .imem_addr(addr_a), .imem_wdata(wdata_a), .load_done(done_a),
        .load_error(err_a), .cpu_rst_n(cpu_a)
    );

    imem_loader #(.ADDR_WIDTH(2)) dut_s (
        .clk(clk), .rst_n(rst_b), .word_in(word_in), .word_valid(valid_b),
        .word_ready(ready_b), .restart(restart & sel), .imem_we(we_b),
        .imem_addr(addr_b), .imem_wdata(wdata_b), .load_done(done_b),
        .load_error(err_b), .cpu_rst_n(cpu_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          errors = 0;
    int          checks = 0;
    int          wa_addr[$];
    logic [31:0] wa_data[$];
    int          wa_cyc[$];
    int          wb_addr[$];
    logic [31:0] wb_data[$];
    int          acc_cyc[$];
    logic [31:0] seq[$];

    always @(negedge clk) begin
        if (we_a) begin
            wa_addr.push_back(int'(addr_a));
            wa_data.push_back(wdata_a);
            wa_cyc.push_back(cyc);
        end
        if (we_b) begin
            wb_addr.push_back(int'(addr_b));
            wb_data.push_back(wdata_b);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        word_in    = w;
        word_valid = 1'b1;
        n = 0;
        while (!word_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) begin
            check("ready_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            #1;
            acc_cyc.push_back(cyc);
        end
        word_valid = 1'b0;
    endtask

    task automatic send_seq();
        foreach (seq[i]) send(seq[i], 0);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_logs();
        wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
        wb_addr.delete(); wb_data.delete(); acc_cyc.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_we"},    64'(we_a),    64'd0);
        check({tag, "_addr"},  64'(addr_a),  64'd0);
        check({tag, "_wdata"}, 64'(wdata_a), 64'd0);
        check({tag, "_done"},  64'(done_a),  64'd0);
        check({tag, "_err"},   64'(err_a),   64'd0);
        check({tag, "_cpu"},   64'(cpu_a),   64'd0);
        check({tag, "_ready"}, 64'(ready_a), 64'd1);
    endtask

    task automatic check_three_writes(input string tag);
        check({tag, "_nwr"}, 64'(wa_addr.size()), 64'd3);
        if (wa_addr.size() == 3) begin
            check({tag, "_a0"}, 64'(wa_addr[0]), 64'd0);
            check({tag, "_d0"}, 64'(wa_data[0]), 64'h11111111);
            check({tag, "_a1"}, 64'(wa_addr[1]), 64'd1);
            check({tag, "_d1"}, 64'(wa_data[1]), 64'h22222222);
            check({tag, "_a2"}, 64'(wa_addr[2]), 64'd2);
            check({tag, "_d2"}, 64'(wa_data[2]), 64'h33333333);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state("rst_in");
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        check_reset_state("rst");

        // 1: good image
        clear_logs();
        seq = '{MAGIC, 32'd3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h66666666};
        send_seq();
        @(negedge clk);
        check_three_writes("t1");
        check("t1_done",  64'(done_a),  64'd1);
        check("t1_cpu",   64'(cpu_a),   64'd1);
        check("t1_err",   64'(err_a),   64'd0);
        check("t1_ready", 64'(ready_a), 64'd0);
        pulse_restart();
        check("t1_rs_ready", 64'(ready_a), 64'd1);
        check("t1_rs_done",  64'(done_a),  64'd0);
        check("t1_rs_cpu",   64'(cpu_a),   64'd0);

        // 2: checksum mismatch
        clear_logs();
        seq[5] = 32'h66666667;
        send_seq();
        @(negedge clk);
        check_three_writes("t2");
        check("t2_err",   64'(err_a),   64'd1);
        check("t2_done",  64'(done_a),  64'd0);
        check("t2_cpu",   64'(cpu_a),   64'd0);
        check("t2_ready", 64'(ready_a), 64'd0);
        pulse_restart();
        check("t2_rs_ready", 64'(ready_a), 64'd1);
        check("t2_rs_err",   64'(err_a),   64'd0);

        // 3: garbage before the image is discarded
        clear_logs();
        send(32'h12345678, 0);
        send(32'hDEADBEEF, 1);
        seq[5] = 32'h66666666;
        send_seq();
        @(negedge clk);
        check_three_writes("t3");
        check("t3_done", 64'(done_a), 64'd1);
        check("t3_cpu",  64'(cpu_a),  64'd1);
        pulse_restart();

        // zero length is rejected
        clear_logs();
        send(MAGIC, 0);
        send(32'd0, 0);
        @(negedge clk);
        check("len0_err", 64'(err_a), 64'd1);
        check("len0_nwr", 64'(wa_addr.size()), 64'd0);
        pulse_restart();

        // 5: gaps between data words; MAGIC inside the image is plain data
        clear_logs();
        send(MAGIC, 0);
        send(32'd4, 2);
        acc_cyc.delete();
        send(MAGIC, 0);
        send(32'd1, 3);
        send(32'd2, 1);
        send(32'd3, 2);
        repeat (4) @(negedge clk);
        check("t5_nwr", 64'(wa_cyc.size()), 64'd4);
        if (wa_cyc.size() == 4 && acc_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t5_lat%0d", i), 64'(wa_cyc[i]), 64'(acc_cyc[i]));
                check($sformatf("t5_addr%0d", i), 64'(wa_addr[i]), 64'(i));
            end
            check("t5_d0", 64'(wa_data[0]), 64'(MAGIC));
            check("t5_d3", 64'(wa_data[3]), 64'd3);
        end
        check("t5_in_check", 64'(ready_a), 64'd1);
        send(32'hB00710B3, 2);
        @(negedge clk);
        check("t5_done", 64'(done_a), 64'd1);
        pulse_restart();

        // 6: reset mid-load, then a fresh image
        clear_logs();
        send(MAGIC, 0);
        send(32'd3, 0);
        send(32'h11111111, 0);
        send(32'h22222222, 0);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check_reset_state("t6_rst");
        @(negedge clk);
        rst_a = 1'b1;
        clear_logs();
        send_seq();
        @(negedge clk);
        check_three_writes("t6");
        check("t6_done", 64'(done_a), 64'd1);
        check("t6_cpu",  64'(cpu_a),  64'd1);

        // 4: DEPTH = 4 instance, over-length then exact-depth image
        sel = 1'b1;
        clear_logs();
        send(MAGIC, 0);
        send(32'd5, 0);
        @(negedge clk);
        check("t4_err",   64'(err_b), 64'd1);
        check("t4_nwr0",  64'(wb_addr.size()), 64'd0);
        check("t4_cpu0",  64'(cpu_b), 64'd0);
        pulse_restart();
        check("t4_rs_ready", 64'(ready_b), 64'd1);
        seq = '{MAGIC, 32'd4, 32'd1, 32'd2, 32'd3, 32'd4, 32'h0000000A};
        send_seq();
        @(negedge clk);
        check("t4_nwr", 64'(wb_addr.size()), 64'd4);
        if (wb_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t4_addr%0d", i), 64'(wb_addr[i]), 64'(i));
                check($sformatf("t4_data%0d", i), 64'(wb_data[i]), 64'(i + 1));
            end
        end
        check("t4_done", 64'(done_b), 64'd1);
        check("t4_err2", 64'(err_b),  64'd0);
        check("t4_cpu",  64'(cpu_b),  64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
